// File: rtl/prbs_rx_checker.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : prbs_rx_checker                                            |
// | Description : Self-synchronising receive PRBS checker with lock FSM and  |
// |               saturating error counter. Define PRBS_CHK_BITCNT_EN to     |
// |               count mismatched bits instead of errored words.            |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module prbs_rx_checker #(
    parameter int DATA_W     = 16,
    parameter int LOCK_CNT   = 8,
    parameter int UNLOCK_CNT = 4,
    parameter int ERR_CNT_W  = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [2:0]           rx_prbs_mode,
    input  logic [DATA_W-1:0]    rx_data,
    input  logic                 rx_valid,
    input  logic                 prbscntreset,
    output logic                 rx_prbs_err,
    output logic                 checker_status,
    output logic                 locked,
    output logic [ERR_CNT_W-1:0] err_count
);

    localparam int c_hist_w = 31;
    localparam int c_ext_w  = DATA_W + c_hist_w;
    localparam int c_good_w = $clog2(LOCK_CNT + 1);
    localparam int c_bad_w  = $clog2(UNLOCK_CNT + 1);
    localparam int c_sum_w  = ERR_CNT_W + 1;

    typedef enum logic [1:0] {
        ST_OFF    = 2'd0,
        ST_SEARCH = 2'd1,
        ST_LOCKED = 2'd2
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic [2:0]            r_mode;
    logic [c_hist_w-1:0]   r_hist;
    logic [c_hist_w-1:0]   w_hist_nxt;
    logic [c_good_w-1:0]   r_good;
    logic [c_good_w-1:0]   w_good_nxt;
    logic [c_bad_w-1:0]    r_bad;
    logic [c_bad_w-1:0]    w_bad_nxt;
    logic                  r_err;
    logic                  w_err_nxt;
    logic                  w_cnt_en;
    logic [ERR_CNT_W-1:0]  r_err_count;
    logic [ERR_CNT_W-1:0]  w_cnt_sat;
    logic [c_sum_w-1:0]    w_sum;
    logic [c_ext_w-1:0]    w_ext;
    logic [DATA_W-1:0]     w_mism;
    logic                  w_zero_word;
    logic                  w_word_err;
    logic                  w_mode_chg;
    logic                  w_new_mode_valid;

    // Current word stacked above the previous 31 received bits; bit c_hist_w+i is b[i].
    assign w_ext            = {rx_data, r_hist};
    assign w_zero_word      = (rx_data == '0);
    assign w_word_err       = (|w_mism) | w_zero_word;
    assign w_mode_chg       = (rx_prbs_mode != r_mode);
    assign w_new_mode_valid = (rx_prbs_mode >= 3'd1) && (rx_prbs_mode <= 3'd4);

    for (genvar i = 0; i < DATA_W; i++) begin : g_bit
        always_comb begin
            case (r_mode)
                3'd1:    w_mism[i] = w_ext[c_hist_w+i] ^ w_ext[c_hist_w+i-6]  ^ w_ext[c_hist_w+i-7];
                3'd2:    w_mism[i] = w_ext[c_hist_w+i] ^ w_ext[c_hist_w+i-14] ^ w_ext[c_hist_w+i-15];
                3'd3:    w_mism[i] = w_ext[c_hist_w+i] ^ w_ext[c_hist_w+i-18] ^ w_ext[c_hist_w+i-23];
                3'd4:    w_mism[i] = w_ext[c_hist_w+i] ^ w_ext[c_hist_w+i-28] ^ w_ext[c_hist_w+i-31];
                default: w_mism[i] = 1'b0;
            endcase
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_good_nxt  = r_good;
        w_bad_nxt   = r_bad;
        w_hist_nxt  = r_hist;
        w_err_nxt   = 1'b0;
        w_cnt_en    = 1'b0;
        if (w_mode_chg) begin
            // The word arriving with a mode change is discarded; checking restarts cleanly.
            w_state_nxt = w_new_mode_valid ? ST_SEARCH : ST_OFF;
            w_good_nxt  = '0;
            w_bad_nxt   = '0;
            w_hist_nxt  = '0;
        end else begin
            case (r_state)
                ST_OFF: begin
                    w_hist_nxt = '0;
                end
                ST_SEARCH: begin
                    if (rx_valid) begin
                        w_hist_nxt = w_ext[c_ext_w-1 -: c_hist_w];
                        w_err_nxt  = w_word_err;
                        if (w_word_err) begin
                            w_good_nxt = '0;
                        end else if (r_good == c_good_w'(LOCK_CNT - 1)) begin
                            w_state_nxt = ST_LOCKED;
                            w_good_nxt  = '0;
                            w_bad_nxt   = '0;
                        end else begin
                            w_good_nxt = r_good + 1'b1;
                        end
                    end
                end
                ST_LOCKED: begin
                    if (rx_valid) begin
                        w_hist_nxt = w_ext[c_ext_w-1 -: c_hist_w];
                        w_err_nxt  = w_word_err;
                        w_cnt_en   = w_word_err;
                        if (!w_word_err) begin
                            w_bad_nxt = '0;
                        end else if (r_bad == c_bad_w'(UNLOCK_CNT - 1)) begin
                            w_state_nxt = ST_SEARCH;
                            w_good_nxt  = '0;
                            w_bad_nxt   = '0;
                        end else begin
                            w_bad_nxt = r_bad + 1'b1;
                        end
                    end
                end
                default: begin
                    w_state_nxt = ST_OFF;
                    w_hist_nxt  = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_OFF;
        end else begin
            r_state <= w_state_nxt;
        end
    end

`ifdef PRBS_CHK_BITCNT_EN
    localparam int c_inc_w = $clog2(DATA_W + 1);
    logic [c_inc_w-1:0] w_inc;

    always_comb begin
        w_inc = '0;
        for (int i = 0; i < DATA_W; i++) begin
            w_inc = w_inc + c_inc_w'(w_mism[i]);
        end
        if (w_zero_word) begin
            w_inc = c_inc_w'(DATA_W);
        end
    end

    assign w_sum = {1'b0, r_err_count} + c_sum_w'(w_inc);
`else
    assign w_sum = {1'b0, r_err_count} + c_sum_w'(1);
`endif

    assign w_cnt_sat = w_sum[ERR_CNT_W] ? '1 : w_sum[ERR_CNT_W-1:0];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_mode      <= 3'd0;
            r_hist      <= '0;
            r_good      <= '0;
            r_bad       <= '0;
            r_err       <= 1'b0;
            r_err_count <= '0;
        end else begin
            r_mode <= rx_prbs_mode;
            r_hist <= w_hist_nxt;
            r_good <= w_good_nxt;
            r_bad  <= w_bad_nxt;
            r_err  <= w_err_nxt;
            if (prbscntreset) begin
                r_err_count <= '0;
            end else if (w_cnt_en) begin
                r_err_count <= w_cnt_sat;
            end
        end
    end

    assign rx_prbs_err    = r_err;
    assign err_count      = r_err_count;
    assign locked         = (r_state == ST_LOCKED);
    assign checker_status = (r_state != ST_LOCKED) | (|r_err_count);

endmodule
`default_nettype wire

// File: tb/tb_prbs_rx_checker.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_prbs_rx_checker                                         |
// | Description : Self-checking bench for prbs_rx_checker: directed vector   |
// |               table, corner-case sequences and randomized traffic.       |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module tb_prbs_rx_checker;

    localparam int DATA_W     = 16;
    localparam int LOCK_CNT   = 8;
    localparam int UNLOCK_CNT = 4;
    localparam int ERR_CNT_W  = 32;
`ifdef PRBS_CHK_BITCNT_EN
    localparam int FLIP_INC = 3;
`else
    localparam int FLIP_INC = 1;
`endif
    localparam longint CNT_MAX = (64'd1 << ERR_CNT_W) - 1;

    logic                 clk = 1'b0;
    logic                 reset = 1'b0;
    logic [2:0]           rx_prbs_mode = 3'd0;
    logic [DATA_W-1:0]    rx_data = '0;
    logic                 rx_valid = 1'b0;
    logic                 prbscntreset = 1'b0;
    logic                 rx_prbs_err;
    logic                 checker_status;
    logic                 locked;
    logic [ERR_CNT_W-1:0] err_count;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    prbs_rx_checker #(
        .DATA_W(DATA_W), .LOCK_CNT(LOCK_CNT), .UNLOCK_CNT(UNLOCK_CNT), .ERR_CNT_W(ERR_CNT_W)
    ) dut (
        .clk(clk), .reset(reset), .rx_prbs_mode(rx_prbs_mode), .rx_data(rx_data),
        .rx_valid(rx_valid), .prbscntreset(prbscntreset), .rx_prbs_err(rx_prbs_err),
        .checker_status(checker_status), .locked(locked), .err_count(err_count)
    );

    function automatic int tap_lo(input logic [2:0] m);
        case (m)
            3'd1: return 6;
            3'd2: return 14;
            3'd3: return 18;
            3'd4: return 28;
            default: return 0;
        endcase
    endfunction

    function automatic int tap_hi(input logic [2:0] m);
        case (m)
            3'd1: return 7;
            3'd2: return 15;
            3'd3: return 23;
            3'd4: return 31;
            default: return 0;
        endcase
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference model: received-bit history as a list, lock state as run lengths.
    bit         m_hist[$];
    int         m_state;   // 0 off, 1 search, 2 locked
    int         m_good, m_bad;
    logic [2:0] m_mode;
    bit         m_err;
    longint     m_cnt;

    function automatic void model_clear_hist();
        m_hist.delete();
        repeat (31) m_hist.push_back(1'b0);
    endfunction

    function automatic void model_reset();
        m_state = 0; m_good = 0; m_bad = 0; m_mode = 3'd0; m_err = 1'b0; m_cnt = 0;
        model_clear_hist();
    endfunction

    function automatic void model_step(input logic [2:0] mode, input bit valid,
                                       input logic [DATA_W-1:0] data, input bit crst);
        bit inc_en = 1'b0;
        int inc = 0;
        if (mode != m_mode) begin
            m_mode = mode;
            model_clear_hist();
            m_good = 0; m_bad = 0; m_err = 1'b0;
            m_state = (tap_hi(mode) != 0) ? 1 : 0;
        end else begin
            m_err = 1'b0;
            if (valid && m_state != 0) begin
                int nm = 0;
                bit werr;
                for (int i = 0; i < DATA_W; i++) begin
                    int n = m_hist.size();
                    bit e = m_hist[n - tap_lo(mode)] ^ m_hist[n - tap_hi(mode)];
                    if (data[i] != e) nm++;
                    m_hist.push_back(data[i]);
                end
                while (m_hist.size() > 31) void'(m_hist.pop_front());
                werr = (nm > 0) || (data == '0);
                m_err = werr;
                if (m_state == 1) begin
                    if (werr) m_good = 0;
                    else begin
                        m_good++;
                        if (m_good == LOCK_CNT) begin m_state = 2; m_good = 0; m_bad = 0; end
                    end
                end else if (werr) begin
                    inc_en = 1'b1;
`ifdef PRBS_CHK_BITCNT_EN
                    inc = (data == '0) ? DATA_W : nm;
`else
                    inc = 1;
`endif
                    m_bad++;
                    if (m_bad == UNLOCK_CNT) begin m_state = 1; m_good = 0; m_bad = 0; end
                end else begin
                    m_bad = 0;
                end
            end
        end
        if (crst) m_cnt = 0;
        else if (inc_en) begin
            m_cnt += inc;
            if (m_cnt > CNT_MAX) m_cnt = CNT_MAX;
        end
    endfunction

    task automatic check_model(input string tag);
        check({tag, "_err"},    64'(rx_prbs_err),    64'(m_err));
        check({tag, "_lock"},   64'(locked),         64'(m_state == 2));
        check({tag, "_cnt"},    64'(err_count),      64'(m_cnt));
        check({tag, "_status"}, 64'(checker_status), 64'((m_state != 2) || (m_cnt != 0)));
    endtask

    // Stimulus generator: transmit-side PRBS bit stream.
    bit         g_q[$];
    logic [2:0] g_mode;

    function automatic void gen_seed(input logic [2:0] m);
        g_mode = m;
        g_q.delete();
        repeat (31) g_q.push_back(bit'($urandom_range(0, 1)));
        g_q[30] = 1'b1;
    endfunction

    function automatic logic [DATA_W-1:0] gen_word();
        logic [DATA_W-1:0] w;
        if (tap_hi(g_mode) == 0) return DATA_W'($urandom);
        for (int i = 0; i < DATA_W; i++) begin
            int n = g_q.size();
            w[i] = g_q[n - tap_lo(g_mode)] ^ g_q[n - tap_hi(g_mode)];
            g_q.push_back(w[i]);
            void'(g_q.pop_front());
        end
        return w;
    endfunction

    // kind: 0 clean, 1 flip bit 0, 2 0xAAAA, 3 all-zero, 4 flip random bit
    function automatic logic [DATA_W-1:0] make_word(input int kind);
        case (kind)
            1: return gen_word() ^ DATA_W'(1);
            2: return DATA_W'(16'hAAAA);
            3: return '0;
            4: return gen_word() ^ (DATA_W'(1) << $urandom_range(0, DATA_W - 1));
            default: return gen_word();
        endcase
    endfunction

    task automatic step(input string tag, input logic [2:0] mode, input bit valid,
                        input logic [DATA_W-1:0] data, input bit crst);
        rx_prbs_mode = mode; rx_valid = valid; rx_data = data; prbscntreset = crst;
        @(posedge clk);
        model_step(mode, valid, data, crst);
        #1;
        check_model(tag);
        @(negedge clk);
    endtask

    typedef struct {
        logic [2:0] mode;
        bit         valid;
        int         kind;
        bit         crst;
        bit         e_err;
        bit         e_lock;
        bit         chk_cnt;
        int         e_units;
        bit         e_stat;
    } vec_t;

    vec_t tbl[$];

    function automatic void add(input logic [2:0] mode, input bit valid, input int kind, input bit crst,
                                input bit e_err, input bit e_lock, input bit chk_cnt,
                                input int e_units, input bit e_stat);
        vec_t v;
        v.mode = mode; v.valid = valid; v.kind = kind; v.crst = crst; v.e_err = e_err;
        v.e_lock = e_lock; v.chk_cnt = chk_cnt; v.e_units = e_units; v.e_stat = e_stat;
        tbl.push_back(v);
    endfunction

    initial begin
        int n;
        logic [DATA_W-1:0] d;

        //   mode valid kind crst | err lock chk units status
        add(3'd1, 0, 0, 0,   0, 0, 1, 0, 1);   // mode change, enters search
        add(3'd1, 1, 0, 0,   1, 0, 1, 0, 1);   // history empty: first word mismatches
        repeat (7) add(3'd1, 1, 0, 0, 0, 0, 1, 0, 1);
        add(3'd1, 1, 0, 0,   0, 1, 1, 0, 0);   // 8th clean word locks
        add(3'd1, 1, 1, 0,   1, 1, 1, 1, 1);
        add(3'd1, 1, 0, 0,   0, 1, 1, 1, 1);
        add(3'd1, 1, 0, 1,   0, 1, 1, 0, 0);
        add(3'd1, 1, 1, 1,   1, 1, 1, 0, 0);   // clear beats increment
        add(3'd1, 1, 0, 0,   0, 1, 1, 0, 0);
        add(3'd1, 1, 1, 0,   1, 1, 1, 1, 1);
        add(3'd1, 1, 1, 0,   1, 1, 1, 2, 1);
        add(3'd1, 1, 1, 0,   1, 1, 1, 3, 1);
        add(3'd1, 1, 0, 0,   0, 1, 1, 3, 1);   // 3-word burst keeps lock
        repeat (3) add(3'd1, 1, 2, 0, 1, 1, 0, 0, 1);
        add(3'd1, 1, 2, 0,   1, 0, 0, 0, 1);   // 4th errored word drops lock
        add(3'd1, 0, 0, 1,   0, 0, 1, 0, 1);

        model_reset();
        #1 reset = 1'b1;
        #1;
        check("rst_err",    64'(rx_prbs_err),    64'(0));
        check("rst_lock",   64'(locked),         64'(0));
        check("rst_cnt",    64'(err_count),      64'(0));
        check("rst_status", 64'(checker_status), 64'(1));
        repeat (2) @(negedge clk);
        reset = 1'b0;
        gen_seed(3'd1);

        for (int r = 0; r < tbl.size(); r++) begin
            d = tbl[r].valid ? make_word(tbl[r].kind) : DATA_W'($urandom);
            step($sformatf("row%0d_model", r), tbl[r].mode, tbl[r].valid, d, tbl[r].crst);
            check($sformatf("row%0d_err", r),    64'(rx_prbs_err),    64'(tbl[r].e_err));
            check($sformatf("row%0d_lock", r),   64'(locked),         64'(tbl[r].e_lock));
            check($sformatf("row%0d_status", r), 64'(checker_status), 64'(tbl[r].e_stat));
            if (tbl[r].chk_cnt)
                check($sformatf("row%0d_cnt", r), 64'(err_count), 64'(tbl[r].e_units * FLIP_INC));
        end

        // Relock on PRBS7 after the unlock.
        n = 0;
        while (!locked && n < 20) begin step("relock7", 3'd1, 1, make_word(0), 0); n++; end
        check("relock7_locked", 64'(locked), 64'(1));

        // Mode switch to PRBS31 drops lock at once, then relocks.
        gen_seed(3'd4);
        step("switch", 3'd4, 1, make_word(0), 0);
        check("switch_unlock", 64'(locked), 64'(0));
        n = 0;
        while (!locked && n < 20) begin step("relock31", 3'd4, 1, make_word(0), 0); n++; end
        check("relock31_locked", 64'(locked), 64'(1));

        // Invalid code 111 behaves as off.
        gen_seed(3'd7);
        repeat (5) begin
            step("off", 3'd7, 1, make_word(0), 0);
            check("off_err", 64'(rx_prbs_err), 64'(0));
        end

        // Asynchronous reset in the middle of a locked, errored stream.
        gen_seed(3'd1);
        repeat (12) step("pre_rst", 3'd1, 1, make_word(0), 0);
        step("pre_rst_flip", 3'd1, 1, make_word(1), 0);
        #2 reset = 1'b1;
        #1;
        check("midrst_err",    64'(rx_prbs_err),    64'(0));
        check("midrst_lock",   64'(locked),         64'(0));
        check("midrst_cnt",    64'(err_count),      64'(0));
        check("midrst_status", 64'(checker_status), 64'(1));
        model_reset();
        @(negedge clk);
        reset = 1'b0;

        // Randomized traffic against the reference model.
        begin
            logic [2:0] cur = 3'd1;
            logic [2:0] picks [10] = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd1, 3'd2, 3'd3, 3'd4, 3'd0, 3'd7};
            gen_seed(cur);
            for (int c = 0; c < 600; c++) begin
                int r;
                int kind;
                bit v;
                bit crst;
                if ($urandom_range(0, 99) < 2) begin
                    cur = picks[$urandom_range(0, 9)];
                    gen_seed(cur);
                end
                v = ($urandom_range(0, 99) < 85);
                crst = ($urandom_range(0, 99) < 3);
                r = $urandom_range(0, 99);
                kind = (r < 5) ? 4 : (r < 7) ? 2 : (r < 9) ? 3 : 0;
                d = v ? make_word(kind) : DATA_W'($urandom);
                step("rand", cur, v, d, crst);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule
`default_nettype wire
